axilite_master_arbiter: RTL

AXILITE_MASTER_ARBITER -- requirements
Module: axilite_master_arbiter

---
 rtl/axilite_master_arbiter_pkg.sv | 33 +++
 rtl/axilite_master_arbiter_rr.sv | 32 +++
 rtl/axilite_master_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/axilite_master_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axilite_master_arbiter_pkg
//
// Definitions shared by the AXI-lite master arbiter and its round-robin
// sub-module:
//   - state_t      : transaction FSM states
//   - ADDR_BASE    : value the AXI address registers hold out of reset
//   - RESP_OKAY / RESP_SLVERR : AXI response codes
//   - grant_onehot : turns a registered requester index into a one-hot vector
// ---------------------------------------------------------------------------
package axilite_master_arbiter_pkg;

   // Transaction FSM. Only one transaction is ever outstanding.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4
   } state_t;

   localparam logic [63:0] ADDR_BASE = 64'h0000_0000_8000_0000;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // The FSM remembers the granted requester as a single index bit. The
   // per-requester response strobe needs it back in one-hot form.
   function automatic logic [1:0] grant_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/axilite_master_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
//
// Purely combinational two-way round-robin arbiter.
//   req  [1:0] : request lines
//   last       : index of the requester granted most recently
//   gnt  [1:0] : one-hot grant, or zero when nobody requests
//
// A lone requester always wins. On a tie, the requester that was not
// granted last time wins.
// ---------------------------------------------------------------------------
module rr_arbiter_2
   import axilite_master_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // Tie-break on the last winner so that two saturating requesters
   // alternate strictly.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/axilite_master_arbiter.sv
// ---------------------------------------------------------------------------
// axilite_master_arbiter
//
// Lets two simple requesters share a single AXI-lite master port. Only one
// transaction is outstanding at a time.
//
// Ports:
//   clk, rst                    : clock and asynchronous active-high reset
//   req_valid/req_ready         : per-requester request handshake. req_ready
//                                 is a one-cycle accept strobe.
//   req_we/req_addr/req_wdata   : per-requester command. The address and data
//                                 buses are packed with requester i in slice i.
//   rsp_valid                   : per-requester one-cycle completion pulse
//   rsp_rdata/rsp_resp          : shared response payload, meaningful only
//                                 while rsp_valid is high
//   m_axi_*                     : AXI-lite master channels AW, W, B, AR and R
//
// Timing with a zero-wait slave:
//   accept (req_ready) -> valid on AW+W or AR -> bready/rready -> rsp_valid.
//   That gives three cycles from req_ready to rsp_valid.
// ---------------------------------------------------------------------------
module axilite_master_arbiter
   import axilite_master_arbiter_pkg::*;
#(
   parameter int AXILITE_ADDR_WIDTH = 64,
   parameter int AXILITE_DATA_WIDTH = 64,
   parameter int NUM_REQ            = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0]                   req_we,
   input  logic [NUM_REQ*AXILITE_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*AXILITE_DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output logic [AXILITE_DATA_WIDTH-1:0]        rsp_rdata,
   output logic [1:0]                           rsp_resp,
   output logic [AXILITE_ADDR_WIDTH-1:0]        m_axi_awaddr,
   output logic                                 m_axi_awvalid,
   input  logic                                 m_axi_awready,
   output logic [AXILITE_DATA_WIDTH-1:0]        m_axi_wdata,
   output logic                                 m_axi_wvalid,
   input  logic                                 m_axi_wready,
   input  logic [1:0]                           m_axi_bresp,
   input  logic                                 m_axi_bvalid,
   output logic                                 m_axi_bready,
   output logic [AXILITE_ADDR_WIDTH-1:0]        m_axi_araddr,
   output logic                                 m_axi_arvalid,
   input  logic                                 m_axi_arready,
   input  logic [AXILITE_DATA_WIDTH-1:0]        m_axi_rdata,
   input  logic [1:0]                           m_axi_rresp,
   input  logic                                 m_axi_rvalid,
   output logic                                 m_axi_rready
);

   localparam int AW = AXILITE_ADDR_WIDTH;
   localparam int DW = AXILITE_DATA_WIDTH;

   state_t         state;
   logic           last_grant;
   logic           grant_idx;
   logic [1:0]     gnt;
   logic           can_grant;
   logic           accept;
   logic           sel_we;
   logic [AW-1:0]  sel_addr;
   logic [DW-1:0]  sel_wdata;
   logic           aw_done;
   logic           w_done;

   rr_arbiter_2 u_rr (
      .req  (req_valid[1:0]),
      .last (last_grant),
      .gnt  (gnt)
   );

   // Grants are offered only in IDLE. They are also held off during the
   // rsp_valid cycle, so the earliest new grant comes one cycle after the
   // response. Gating with rst keeps req_ready low for the whole reset,
   // even while requesters are still asserting req_valid.
   always_comb begin
      can_grant = (state == IDLE) && (rsp_valid == '0) && !rst;
      req_ready = can_grant ? gnt : 2'b00;
      accept    = can_grant && (gnt != 2'b00);
   end

   // Pick the command fields of whichever requester won arbitration.
   always_comb begin
      sel_we    = gnt[1] ? req_we[1] : req_we[0];
      sel_addr  = gnt[1] ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
      sel_wdata = gnt[1] ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
   end

   // AW and W complete independently. A channel counts as done once its
   // valid has already dropped, or when it is handshaking this cycle. This
   // covers both channels finishing on the same edge.
   always_comb begin
      aw_done = !m_axi_awvalid || m_axi_awready;
      w_done  = !m_axi_wvalid  || m_axi_wready;
   end

   // Single FSM block. Every AXI-side valid, ready, address and data signal
   // is a register, so it can only change on a clock edge. A valid is cleared
   // only in the cycle where its handshake completes. B and R beats that
   // arrive outside WR_RESP or RD_RESP are ignored, because bready/rready
   // are low there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         grant_idx     <= 1'b0;
         m_axi_awaddr  <= ADDR_BASE[AW-1:0];
         m_axi_araddr  <= ADDR_BASE[AW-1:0];
         m_axi_wdata   <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= '0;
         rsp_rdata     <= '0;
         rsp_resp      <= RESP_OKAY;
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant <= gnt[1];
                  grant_idx  <= gnt[1];
                  if (sel_we) begin
                     m_axi_awaddr  <= sel_addr;
                     m_axi_wdata   <= sel_wdata;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= WR_REQ;
                  end else begin
                     m_axi_araddr  <= sel_addr;
                     m_axi_arvalid <= 1'b1;
                     state         <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (m_axi_awvalid && m_axi_awready) begin
                  m_axi_awvalid <= 1'b0;
               end
               if (m_axi_wvalid && m_axi_wready) begin
                  m_axi_wvalid <= 1'b0;
               end
               if (aw_done && w_done) begin
                  m_axi_bready <= 1'b1;
                  state        <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  rsp_valid    <= grant_onehot(grant_idx);
                  rsp_resp     <= m_axi_bresp;
                  rsp_rdata    <= '0;
                  state        <= IDLE;
               end
            end
            RD_REQ: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  rsp_valid    <= grant_onehot(grant_idx);
                  rsp_resp     <= m_axi_rresp;
                  rsp_rdata    <= m_axi_rdata;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
